// File: rtl/dcm_clk_pkg.sv
// Shared constants and helpers for the divided-clock generator.
// Default ratios give 40/50/10 MHz from a 200 MHz reference.
package dcm_clk_pkg;

    localparam int CNT_W = 16;

    localparam int DEF_DIV1        = 5;
    localparam int DEF_DIV2        = 4;
    localparam int DEF_DIV3        = 20;
    localparam int DEF_LOCK_CYCLES = 64;

    // Number of input cycles a divided clock spends high; odd ratios round up.
    function automatic int half_high(input int div);
        return (div + 1) / 2;
    endfunction

endpackage

// File: rtl/clk_div_cell.sv
// One integer clock divider: a wrapping counter plus a registered output.
// Latency: output rises on the first enabled edge; no backpressure, free-running while run_en is high.
// run_en low holds the counter and output at 0 so the divider restarts in phase.
module clk_div_cell
    import dcm_clk_pkg::*;
#(
    parameter int DIV = DEF_DIV1
) (
    input  logic CLK_IN1,
    input  logic RESET_N,
    input  logic run_en,
    output logic clk_out
);

    if (DIV < 2 || DIV > 65535) begin : g_bad_div
        $error("clk_div_cell: DIV=%0d outside legal range 2..65535", DIV);
    end

    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] HIGH_CNT = CNT_W'(half_high(DIV));

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge CLK_IN1 or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt     <= '0;
            clk_out <= 1'b0;
        end else if (!run_en) begin
            cnt     <= '0;
            clk_out <= 1'b0;
        end else begin
            cnt     <= (cnt == DIV_LAST) ? '0 : cnt + 1'b1;
            // Decided from the pre-update count so the first enabled edge drives high.
            clk_out <= (cnt < HIGH_CNT);
        end
    end

endmodule

// File: rtl/dcm_clk_gen.sv
// Three phase-aligned divided clocks from CLK_IN1, plus a LOCKED flag after LOCK_CYCLES edges.
// Latency: outputs rise on the first edge after release (DCM_OUT_GATE_EN: one edge after LOCKED).
// No backpressure; all outputs come straight from flops.
module dcm_clk_gen
    import dcm_clk_pkg::*;
#(
    parameter int DIV1        = DEF_DIV1,
    parameter int DIV2        = DEF_DIV2,
    parameter int DIV3        = DEF_DIV3,
    parameter int LOCK_CYCLES = DEF_LOCK_CYCLES
) (
    input  logic CLK_IN1,
    input  logic RESET_N,
    output logic CLK_OUT1,
    output logic CLK_OUT2,
    output logic CLK_OUT3,
    output logic LOCKED
);

    if (LOCK_CYCLES < 1 || LOCK_CYCLES > 65535) begin : g_bad_lock
        $error("dcm_clk_gen: LOCK_CYCLES=%0d outside legal range 1..65535", LOCK_CYCLES);
    end

    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_SAT  = CNT_W'(LOCK_CYCLES);

    logic [CNT_W-1:0] lock_cnt;
    logic             run_en;

    // LOCKED is set on the edge where the pre-update count reaches LOCK_CYCLES-1.
    always_ff @(posedge CLK_IN1 or negedge RESET_N) begin
        if (!RESET_N) begin
            lock_cnt <= '0;
            LOCKED   <= 1'b0;
        end else begin
            if (lock_cnt < LOCK_SAT) begin
                lock_cnt <= lock_cnt + 1'b1;
            end
            if (lock_cnt == LOCK_LAST) begin
                LOCKED <= 1'b1;
            end
        end
    end

`ifdef DCM_OUT_GATE_EN
    assign run_en = LOCKED;
`else
    assign run_en = 1'b1;
`endif

    clk_div_cell #(.DIV(DIV1)) u_div1 (
        .CLK_IN1 (CLK_IN1),
        .RESET_N (RESET_N),
        .run_en  (run_en),
        .clk_out (CLK_OUT1)
    );

    clk_div_cell #(.DIV(DIV2)) u_div2 (
        .CLK_IN1 (CLK_IN1),
        .RESET_N (RESET_N),
        .run_en  (run_en),
        .clk_out (CLK_OUT2)
    );

    clk_div_cell #(.DIV(DIV3)) u_div3 (
        .CLK_IN1 (CLK_IN1),
        .RESET_N (RESET_N),
        .run_en  (run_en),
        .clk_out (CLK_OUT3)
    );

endmodule

// File: tb/tb_dcm_clk_gen.sv
// Directed bench for dcm_clk_gen: default ratios and a 2/3/7, LOCK_CYCLES=1 instance side by side.
module tb_dcm_clk_gen;

    logic clk_40m = 1'b0;
    logic rst_n   = 1'b0;

    logic a_out1, a_out2, a_out3, a_locked;
    logic b_out1, b_out2, b_out3, b_locked;

    int checks = 0;
    int errors = 0;
    int ecnt   = 0;

`ifdef DCM_OUT_GATE_EN
    localparam bit GATED = 1'b1;
`else
    localparam bit GATED = 1'b0;
`endif

    localparam int A_LOCK = 64;
    localparam int B_LOCK = 1;
    localparam int A_START = GATED ? A_LOCK + 1 : 1;
    localparam int B_START = GATED ? B_LOCK + 1 : 1;

    int div_tab [6] = '{5, 4, 20, 2, 3, 7};
    int prev_v [6];
    int last_rise [6];

    always #5 clk_40m = ~clk_40m;

    dcm_clk_gen u_dut_a (
        .CLK_IN1  (clk_40m),
        .RESET_N  (rst_n),
        .CLK_OUT1 (a_out1),
        .CLK_OUT2 (a_out2),
        .CLK_OUT3 (a_out3),
        .LOCKED   (a_locked)
    );

    dcm_clk_gen #(.DIV1(2), .DIV2(3), .DIV3(7), .LOCK_CYCLES(B_LOCK)) u_dut_b (
        .CLK_IN1  (clk_40m),
        .RESET_N  (rst_n),
        .CLK_OUT1 (b_out1),
        .CLK_OUT2 (b_out2),
        .CLK_OUT3 (b_out3),
        .LOCKED   (b_locked)
    );

    // Expected divided clock after edge k, where start is the first edge driving high.
    function automatic logic exp_clk(input int div, input int k, input int start);
        if (k < start) return 1'b0;
        return (((k - start) % div) < ((div + 1) / 2));
    endfunction

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s edge %0d observed %b expected %b", tag, ecnt, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s edge %0d observed %0d expected %0d", tag, ecnt, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_40m);
        #1;
        ecnt++;
    endtask

    task automatic clear_trackers();
        for (int i = 0; i < 6; i++) begin
            prev_v[i]    = 0;
            last_rise[i] = 0;
        end
    endtask

    // Rising-edge period measurement on each of the six outputs.
    task automatic track_periods();
        logic [5:0] cur;
        cur = {b_out3, b_out2, b_out1, a_out3, a_out2, a_out1};
        for (int i = 0; i < 6; i++) begin
            if (prev_v[i] == 0 && cur[i] == 1'b1) begin
                if (last_rise[i] != 0) chk_int($sformatf("period%0d", i), ecnt - last_rise[i], div_tab[i]);
                last_rise[i] = ecnt;
            end
            prev_v[i] = int'(cur[i]);
        end
    endtask

    task automatic check_edge();
        chk("a_out1", a_out1, exp_clk(5, ecnt, A_START));
        chk("a_out2", a_out2, exp_clk(4, ecnt, A_START));
        chk("a_out3", a_out3, exp_clk(20, ecnt, A_START));
        chk("a_locked", a_locked, ecnt >= A_LOCK);
        chk("b_out1", b_out1, exp_clk(2, ecnt, B_START));
        chk("b_out2", b_out2, exp_clk(3, ecnt, B_START));
        chk("b_out3", b_out3, exp_clk(7, ecnt, B_START));
        chk("b_locked", b_locked, ecnt >= B_LOCK);
        track_periods();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_a1"}, a_out1, 1'b0);
        chk({tag, "_a2"}, a_out2, 1'b0);
        chk({tag, "_a3"}, a_out3, 1'b0);
        chk({tag, "_alk"}, a_locked, 1'b0);
        chk({tag, "_b1"}, b_out1, 1'b0);
        chk({tag, "_b2"}, b_out2, 1'b0);
        chk({tag, "_b3"}, b_out3, 1'b0);
        chk({tag, "_blk"}, b_locked, 1'b0);
    endtask

    initial begin
        clear_trackers();

        // Held in reset across several edges: everything stays at 0.
        repeat (4) @(posedge clk_40m);
        #1;
        check_all_zero("reset");

        // Release between edges; edge 1 is the first rising edge afterwards.
        #3;
        rst_n = 1'b1;
        ecnt  = 0;
        for (int k = 0; k < 68; k++) begin
            tick();
            check_edge();
        end

        // Hand-picked vectors for the default build at a few landmark edges.
        if (!GATED) begin
            chk_int("a_out1_edge68", int'(a_out1), 1);  // (68-1)%5=2 -> high
            chk_int("a_out2_edge68", int'(a_out2), 0);  // (68-1)%4=3 -> low
            chk_int("a_out3_edge68", int'(a_out3), 1);  // (68-1)%20=7 -> high
        end else begin
            chk_int("a_out3_edge68_g", int'(a_out3), 1); // (68-65)%20=3 -> high
        end

        // Mid CLK_OUT3 high phase, between edges: asynchronous clear.
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        #1;
        check_all_zero("async_rst_hold");

        @(posedge clk_40m);
        #3;
        rst_n = 1'b1;
        ecnt  = 0;
        clear_trackers();
        for (int k = 0; k < 1100; k++) begin
            tick();
            check_edge();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout edge %0d observed running expected finished", ecnt);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
